// File: rtl/cpu_run_ctrl_pkg.sv
// Shared constants for the CPU run/step/halt controller.
// The state encodings are also decoded by the CPU top level and the debug display.
package cpu_run_ctrl_pkg;

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_RUN       = 2'b01;
    localparam logic [1:0] ST_STEP_WAIT = 2'b10;
    localparam logic [1:0] ST_HALTED    = 2'b11;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_CNT_WIDTH       = 16;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-side bundle of the run controller: divided clock, buttons and halt in,
// CPU enable and status out.
interface cpu_run_ctrl_if
    import cpu_run_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                 SlowClk;
    logic                 BtnRun;
    logic                 BtnStep;
    logic                 Halt;
    logic                 CpuEn;
    logic                 Running;
    logic [CNT_WIDTH-1:0] CycleCount;
    logic [1:0]           StateOut;

    modport master (
        output SlowClk, BtnRun, BtnStep, Halt,
        input  CpuEn, Running, CycleCount, StateOut
    );

    modport slave (
        input  SlowClk, BtnRun, BtnStep, Halt,
        output CpuEn, Running, CycleCount, StateOut
    );
endinterface

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press event on the debounced 0->1 transition only.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the debounced level restarts the qualification.
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Turns the divided clock into a single-cycle CPU enable, gated by a
// run/step/halt FSM driven by two debounced buttons and the core halt flag.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic          Clkin,
    input  logic          Rst,
    cpu_run_ctrl_if.slave bus
);
    logic run_press;
    logic step_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clk     (Clkin),
        .rst     (Rst),
        .btn_raw (bus.BtnRun),
        .press   (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk     (Clkin),
        .rst     (Rst),
        .btn_raw (bus.BtnStep),
        .press   (step_press)
    );

    logic                 slow_s1_q, slow_s1_d;
    logic                 slow_s2_q, slow_s2_d;
    logic                 slow_s3_q, slow_s3_d;
    logic                 tick_q, tick_d;
    logic [1:0]           state_q, state_d;
    logic                 cpu_en_q, cpu_en_d;
    logic                 running_q, running_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // The tick is registered like the button press events, so both event
    // kinds reach the FSM with the same pipeline alignment.
    always_comb begin
        slow_s1_d = bus.SlowClk;
        slow_s2_d = slow_s1_q;
        slow_s3_d = slow_s2_q;
        tick_d    = slow_s2_q & ~slow_s3_q;
    end

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_press)       state_d = ST_RUN;
                else if (step_press) state_d = ST_STEP_WAIT;
            end
            ST_RUN: begin
                if (bus.Halt)       state_d = ST_HALTED;
                else if (run_press) state_d = ST_IDLE;
                else if (tick_q)    cpu_en_d = 1'b1;
            end
            ST_STEP_WAIT: begin
                if (bus.Halt)       state_d = ST_HALTED;
                else if (run_press) state_d = ST_RUN;
                else if (tick_q) begin
                    cpu_en_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (run_press && !bus.Halt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        count_d   = cpu_en_d ? count_q + CNT_WIDTH'(1) : count_q;
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge Clkin or posedge Rst) begin
        if (Rst) begin
            slow_s1_q <= 1'b0;
            slow_s2_q <= 1'b0;
            slow_s3_q <= 1'b0;
            tick_q    <= 1'b0;
            state_q   <= ST_IDLE;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            count_q   <= '0;
        end else begin
            slow_s1_q <= slow_s1_d;
            slow_s2_q <= slow_s2_d;
            slow_s3_q <= slow_s3_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
            count_q   <= count_d;
        end
    end

    assign bus.CpuEn      = cpu_en_q;
    assign bus.Running    = running_q;
    assign bus.CycleCount = count_q;
    assign bus.StateOut   = state_q;

endmodule
